// File: rtl/mlp_train_scheduler_pkg.sv
// Shared types and defaults for the MLP training scheduler and its sample buffer.
package mlp_train_scheduler_pkg;

  localparam int DEFAULT_INPUT_SIZE    = 2;
  localparam int DEFAULT_OUTPUT_SIZE   = 1;
  localparam int DEFAULT_MAX_SAMPLES   = 16;
  localparam int DEFAULT_SETTLE_CYCLES = 2;
  localparam int EPOCH_W               = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRESENT,
    EVAL,
    TRAIN,
    EPOCH_END,
    DONE
  } train_state_t;

  // Squared difference between a prediction and its target.
  function automatic real sq_err(input real pred, input real tgt);
    real d;
    d = pred - tgt;
    return d * d;
  endfunction

endpackage

// File: rtl/mlp_train_scheduler_if.sv
// Host-side control/status bus of the training scheduler.
interface mlp_train_scheduler_if
  import mlp_train_scheduler_pkg::*;
#(
  parameter int INPUT_SIZE  = DEFAULT_INPUT_SIZE,
  parameter int OUTPUT_SIZE = DEFAULT_OUTPUT_SIZE,
  parameter int MAX_SAMPLES = DEFAULT_MAX_SAMPLES
);
  localparam int AW = $clog2(MAX_SAMPLES);

  // Host -> scheduler
  logic                start;
  logic                stop;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  real                 wr_inputs  [INPUT_SIZE];
  real                 wr_targets [OUTPUT_SIZE];
  logic [AW:0]         num_samples;
  logic [EPOCH_W-1:0]  max_epochs;
  real                 err_threshold;
  real                 lr_init;
  logic [EPOCH_W-1:0]  lr_decay_interval;

  // Scheduler -> host
  logic                busy;
  logic                done;
  logic                converged;
  logic [EPOCH_W-1:0]  epoch_count;
  real                 epoch_error;
  logic [AW-1:0]       sample_idx;

  modport master (
    output start, stop, wr_en, wr_addr, wr_inputs, wr_targets, num_samples,
           max_epochs, err_threshold, lr_init, lr_decay_interval,
    input  busy, done, converged, epoch_count, epoch_error, sample_idx
  );

  modport slave (
    input  start, stop, wr_en, wr_addr, wr_inputs, wr_targets, num_samples,
           max_epochs, err_threshold, lr_init, lr_decay_interval,
    output busy, done, converged, epoch_count, epoch_error, sample_idx
  );

endinterface

// File: rtl/mlp_sample_buffer.sv
// Sample store: one synchronous write port, one combinational read port. Not reset.
module mlp_sample_buffer
  import mlp_train_scheduler_pkg::*;
#(
  parameter int INPUT_SIZE  = DEFAULT_INPUT_SIZE,
  parameter int OUTPUT_SIZE = DEFAULT_OUTPUT_SIZE,
  parameter int MAX_SAMPLES = DEFAULT_MAX_SAMPLES,
  localparam int AW         = $clog2(MAX_SAMPLES)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  real           i_wr_inputs  [INPUT_SIZE],
  input  real           i_wr_targets [OUTPUT_SIZE],
  input  logic [AW-1:0] i_rd_addr,
  output real           o_rd_inputs  [INPUT_SIZE],
  output real           o_rd_targets [OUTPUT_SIZE]
);

  real  r_inputs  [MAX_SAMPLES][INPUT_SIZE];
  real  r_targets [MAX_SAMPLES][OUTPUT_SIZE];
  logic w_addr_ok;

  // Out-of-range write addresses only exist when the depth is not a power of two.
  generate
    if ((1 << AW) > MAX_SAMPLES) begin : g_addr_chk
      assign w_addr_ok = (int'(i_wr_addr) < MAX_SAMPLES);
    end else begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end
  endgenerate

  // Store one full sample (inputs and targets) per write strobe.
  always_ff @(posedge clk) begin
    if (i_wr_en && w_addr_ok) begin
      for (int i = 0; i < INPUT_SIZE; i++) r_inputs[i_wr_addr][i] <= i_wr_inputs[i];
      for (int i = 0; i < OUTPUT_SIZE; i++) r_targets[i_wr_addr][i] <= i_wr_targets[i];
    end
  end

  generate
    for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_rd_in
      assign o_rd_inputs[gi] = r_inputs[i_rd_addr][gi];
    end
    for (genvar gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_rd_tgt
      assign o_rd_targets[gi] = r_targets[i_rd_addr][gi];
    end
  endgenerate

endmodule

// File: rtl/mlp_train_scheduler.sv
// Epoch/sample sequencer driving the MLP training ports and tracking per-epoch SSE.
module mlp_train_scheduler
  import mlp_train_scheduler_pkg::*;
#(
  parameter int INPUT_SIZE    = DEFAULT_INPUT_SIZE,
  parameter int OUTPUT_SIZE   = DEFAULT_OUTPUT_SIZE,
  parameter int MAX_SAMPLES   = DEFAULT_MAX_SAMPLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  mlp_train_scheduler_if.slave        bus,
  input  real                         i_mlp_outputs [OUTPUT_SIZE],
  output real                         o_mlp_inputs  [INPUT_SIZE],
  output real                         o_mlp_targets [OUTPUT_SIZE],
  output logic                        o_mlp_training,
  output real                         o_mlp_learning_rate
);

  localparam int AW = $clog2(MAX_SAMPLES);
  localparam int NW = AW + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [NW-1:0] MAX_N       = NW'(MAX_SAMPLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  train_state_t        r_state,       w_state_next;
  logic [AW-1:0]       r_idx,         w_idx_next;
  logic [SW-1:0]       r_settle,      w_settle_next;
  real                 r_acc,         w_acc_next;
  logic [EPOCH_W-1:0]  r_epoch_count, w_epoch_count_next;
  real                 r_epoch_error, w_epoch_error_next;
  real                 r_lr,          w_lr_next;
  logic                r_converged,   w_converged_next;
  logic [NW-1:0]       r_num,         w_num_next;
  logic [EPOCH_W-1:0]  r_max_ep,      w_max_ep_next;
  real                 r_thresh,      w_thresh_next;
  logic [EPOCH_W-1:0]  r_decay,       w_decay_next;

  logic                w_busy;
  logic                w_wr_en;
  logic [NW-1:0]       w_num_clamped;
  logic [EPOCH_W-1:0]  w_count_inc;
  real                 w_sample_sse;
  real                 w_rd_inputs  [INPUT_SIZE];
  real                 w_rd_targets [OUTPUT_SIZE];

  assign w_busy = (r_state == PRESENT) || (r_state == EVAL) ||
                  (r_state == TRAIN)   || (r_state == EPOCH_END);
  // Host writes are only accepted while no run is using the buffer.
  assign w_wr_en       = bus.wr_en && !w_busy;
  assign w_num_clamped = (bus.num_samples > MAX_N) ? MAX_N : bus.num_samples;
  assign w_count_inc   = (r_epoch_count == {EPOCH_W{1'b1}}) ? r_epoch_count
                                                            : r_epoch_count + 1'b1;

  mlp_sample_buffer #(
    .INPUT_SIZE  (INPUT_SIZE),
    .OUTPUT_SIZE (OUTPUT_SIZE),
    .MAX_SAMPLES (MAX_SAMPLES)
  ) u_buffer (
    .clk          (clk),
    .i_wr_en      (w_wr_en),
    .i_wr_addr    (bus.wr_addr),
    .i_wr_inputs  (bus.wr_inputs),
    .i_wr_targets (bus.wr_targets),
    .i_rd_addr    (r_idx),
    .o_rd_inputs  (w_rd_inputs),
    .o_rd_targets (w_rd_targets)
  );

  // Squared error of the currently presented sample against the MLP prediction.
  always_comb begin
    w_sample_sse = 0.0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      w_sample_sse = w_sample_sse + sq_err(i_mlp_outputs[i], w_rd_targets[i]);
    end
  end

  // Next-state and next-register values for the run sequencer.
  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_settle_next      = r_settle;
    w_acc_next         = r_acc;
    w_epoch_count_next = r_epoch_count;
    w_epoch_error_next = r_epoch_error;
    w_lr_next          = r_lr;
    w_converged_next   = r_converged;
    w_num_next         = r_num;
    w_max_ep_next      = r_max_ep;
    w_thresh_next      = r_thresh;
    w_decay_next       = r_decay;

    if (bus.stop && (r_state != IDLE)) begin
      // Abort wins over everything, including a same-cycle start from DONE.
      w_state_next     = IDLE;
      w_idx_next       = '0;
      w_settle_next    = '0;
      w_converged_next = 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start && !bus.stop) begin
            w_num_next         = w_num_clamped;
            w_max_ep_next      = bus.max_epochs;
            w_thresh_next      = bus.err_threshold;
            w_decay_next       = bus.lr_decay_interval;
            w_lr_next          = bus.lr_init;
            w_idx_next         = '0;
            w_settle_next      = '0;
            w_acc_next         = 0.0;
            w_epoch_count_next = '0;
            w_converged_next   = 1'b0;
            if ((w_num_clamped == '0) || (bus.max_epochs == '0)) w_state_next = DONE;
            else                                                   w_state_next = PRESENT;
          end
        end
        PRESENT: begin
          if (r_settle == SETTLE_LAST) w_state_next  = EVAL;
          else                         w_settle_next = r_settle + 1'b1;
        end
        EVAL: begin
          w_acc_next   = r_acc + w_sample_sse;
          w_state_next = TRAIN;
        end
        TRAIN: begin
          if ({1'b0, r_idx} == (r_num - 1'b1)) begin
            w_state_next = EPOCH_END;
          end else begin
            w_idx_next    = r_idx + 1'b1;
            w_settle_next = '0;
            w_state_next  = PRESENT;
          end
        end
        EPOCH_END: begin
          w_epoch_error_next = r_acc;
          w_epoch_count_next = w_count_inc;
          w_acc_next         = 0.0;
          w_idx_next         = '0;
          w_settle_next      = '0;
          // Convergence is tested first so a final-epoch convergence still reports converged.
          if (r_acc < r_thresh) begin
            w_state_next     = DONE;
            w_converged_next = 1'b1;
          end else if (w_count_inc == r_max_ep) begin
            w_state_next = DONE;
          end else begin
            if ((r_decay != '0) && ((w_count_inc % r_decay) == '0)) w_lr_next = r_lr * 0.5;
            w_state_next = PRESENT;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset returns every visible output to its idle value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_settle      <= '0;
      r_acc         <= 0.0;
      r_epoch_count <= '0;
      r_epoch_error <= 0.0;
      r_lr          <= 0.0;
      r_converged   <= 1'b0;
      r_num         <= '0;
      r_max_ep      <= '0;
      r_thresh      <= 0.0;
      r_decay       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_settle      <= w_settle_next;
      r_acc         <= w_acc_next;
      r_epoch_count <= w_epoch_count_next;
      r_epoch_error <= w_epoch_error_next;
      r_lr          <= w_lr_next;
      r_converged   <= w_converged_next;
      r_num         <= w_num_next;
      r_max_ep      <= w_max_ep_next;
      r_thresh      <= w_thresh_next;
      r_decay       <= w_decay_next;
    end
  end

  assign bus.busy            = w_busy;
  assign bus.done            = (r_state == DONE);
  assign bus.converged       = r_converged;
  assign bus.epoch_count     = r_epoch_count;
  assign bus.epoch_error     = r_epoch_error;
  assign bus.sample_idx      = r_idx;
  assign o_mlp_training      = (r_state == TRAIN);
  assign o_mlp_learning_rate = r_lr;

  // The MLP sees the current sample only while a run is active, zeros otherwise.
  generate
    for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_mlp_in
      assign o_mlp_inputs[gi] = w_busy ? w_rd_inputs[gi] : 0.0;
    end
    for (genvar gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_mlp_tgt
      assign o_mlp_targets[gi] = w_busy ? w_rd_targets[gi] : 0.0;
    end
  endgenerate

endmodule

// File: tb/tb_mlp_train_scheduler.sv
// Self-checking bench for mlp_train_scheduler with a linear stub MLP and a run-level model.
module tb_mlp_train_scheduler;

  localparam int IN   = 2;
  localparam int OUT  = 1;
  localparam int MAXS = 16;
  localparam int S    = 2;
  localparam int AW   = 4;
  localparam int NW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mlp_train_scheduler_if #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .MAX_SAMPLES(MAXS)) bus ();

  real  mlp_out [OUT];
  real  mlp_in  [IN];
  real  mlp_tgt [OUT];
  logic mlp_training;
  real  mlp_lr;

  mlp_train_scheduler #(
    .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .MAX_SAMPLES(MAXS), .SETTLE_CYCLES(S)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .i_mlp_outputs       (mlp_out),
    .o_mlp_inputs        (mlp_in),
    .o_mlp_targets       (mlp_tgt),
    .o_mlp_training      (mlp_training),
    .o_mlp_learning_rate (mlp_lr)
  );

  // Stub MLP: prediction = a*x0 + b*x1 + c
  real stub_a, stub_b, stub_c;
  always_comb mlp_out[0] = stub_a * mlp_in[0] + stub_b * mlp_in[1] + stub_c;

  // Reference model state
  real m_in  [MAXS][IN];
  real m_tgt [MAXS][OUT];
  int  cur_n, cur_ep, cur_dec;
  real cur_lr0, cur_thr;
  int  pulses, busy_cycles, mon_k;
  logic train_prev;
  int  checks = 0;
  int  errors = 0;

  task automatic chk_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %f expected %f", tag, obs, exp);
    end
  endtask

  function automatic real stub_f(input int k);
    return stub_a * m_in[k][0] + stub_b * m_in[k][1] + stub_c;
  endfunction

  function automatic real model_sse(input int n);
    real s, d;
    s = 0.0;
    for (int k = 0; k < n; k++) begin
      d = stub_f(k) - m_tgt[k][0];
      s = s + d * d;
    end
    return s;
  endfunction

  // Learning rate in force during the epoch containing training pulse p.
  function automatic real model_lr(input int p);
    real lr;
    int  ep0;
    lr  = cur_lr0;
    ep0 = p / cur_n;
    if (cur_dec != 0) for (int h = 0; h < ep0 / cur_dec; h++) lr = lr / 2.0;
    return lr;
  endfunction

  function automatic real rnd_q();
    return (real'($urandom_range(32)) - 16.0) / 8.0;
  endfunction

  // Per-pulse monitor: the k-th pulse of a run must present sample k mod N with the scheduled rate.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (mlp_training === 1'b1) begin
        mon_k = pulses % cur_n;
        chk_int("train_single_cycle", 32'(train_prev), 32'd0);
        chk_int("pulse_sample_idx", 32'(bus.sample_idx), 32'(mon_k));
        chk_real("pulse_in0", mlp_in[0], m_in[mon_k][0]);
        chk_real("pulse_in1", mlp_in[1], m_in[mon_k][1]);
        chk_real("pulse_tgt", mlp_tgt[0], m_tgt[mon_k][0]);
        chk_real("pulse_lr", mlp_lr, model_lr(pulses));
        pulses++;
      end
      train_prev = mlp_training;
    end
  end

  task automatic write_sample(input int a, input real x0, input real x1, input real t,
                              input bit taken);
    @(negedge clk);
    bus.wr_en         = 1'b1;
    bus.wr_addr       = AW'(a);
    bus.wr_inputs[0]  = x0;
    bus.wr_inputs[1]  = x1;
    bus.wr_targets[0] = t;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (taken) begin
      m_in[a][0]  = x0;
      m_in[a][1]  = x1;
      m_tgt[a][0] = t;
    end
  endtask

  task automatic launch(input int n, input int ep, input real thr, input real lr0, input int dec);
    @(negedge clk);
    bus.num_samples       = NW'(n);
    bus.max_epochs        = 16'(ep);
    bus.err_threshold     = thr;
    bus.lr_init           = lr0;
    bus.lr_decay_interval = 16'(dec);
    cur_n   = (n > MAXS) ? MAXS : n;
    cur_ep  = ep;
    cur_thr = thr;
    cur_lr0 = lr0;
    cur_dec = dec;
    pulses      = 0;
    busy_cycles = 0;
    train_prev  = 1'b0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (bus.done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk_int("done_within_budget", 32'(bus.done), 32'd1);
  endtask

  task automatic wait_train(input int min_epoch, input int budget);
    int c;
    c = 0;
    while (!(mlp_training === 1'b1 && int'(bus.epoch_count) >= min_epoch) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk_int("train_seen_within_budget", 32'(mlp_training), 32'd1);
  endtask

  task automatic check_result(input string tag);
    int  ep_exp;
    bit  conv_exp;
    real sse;
    sse = model_sse(cur_n);
    if (cur_n == 0 || cur_ep == 0) begin ep_exp = 0; conv_exp = 1'b0; end
    else if (sse < cur_thr)        begin ep_exp = 1; conv_exp = 1'b1; end
    else                           begin ep_exp = cur_ep; conv_exp = 1'b0; end
    chk_int({tag, ".epoch_count"}, 32'(bus.epoch_count), 32'(ep_exp));
    chk_int({tag, ".converged"}, 32'(bus.converged), 32'(conv_exp));
    chk_int({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk_int({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(ep_exp * (cur_n * (S + 2) + 1)));
    chk_int({tag, ".pulses"}, 32'(pulses), 32'(ep_exp * cur_n));
    if (ep_exp > 0) chk_real({tag, ".epoch_error"}, bus.epoch_error, sse);
    $display("run %s n=%0d ep=%0d -> epochs=%0d conv=%0d sse=%f", tag, cur_n, cur_ep,
             bus.epoch_count, bus.converged, bus.epoch_error);
  endtask

  initial begin
    int n, ep, dec;
    real thr;
    stub_a = 0.0; stub_b = 0.0; stub_c = 0.5;
    cur_n = 1; cur_ep = 0; cur_dec = 0; cur_lr0 = 0.0; cur_thr = 0.0;
    pulses = 0; busy_cycles = 0; train_prev = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_inputs[0] = 0.0; bus.wr_inputs[1] = 0.0; bus.wr_targets[0] = 0.0;
    bus.num_samples = '0; bus.max_epochs = '0; bus.err_threshold = 0.0;
    bus.lr_init = 0.0; bus.lr_decay_interval = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk_int("rst.busy", 32'(bus.busy), 32'd0);
    chk_int("rst.done", 32'(bus.done), 32'd0);
    chk_int("rst.converged", 32'(bus.converged), 32'd0);
    chk_int("rst.training", 32'(mlp_training), 32'd0);
    chk_int("rst.epoch_count", 32'(bus.epoch_count), 32'd0);
    chk_int("rst.sample_idx", 32'(bus.sample_idx), 32'd0);
    chk_real("rst.epoch_error", bus.epoch_error, 0.0);
    chk_real("rst.lr", mlp_lr, 0.0);
    chk_real("rst.in0", mlp_in[0], 0.0);
    chk_real("rst.tgt", mlp_tgt[0], 0.0);
    rst = 1'b0;

    // XOR set against constant 0.5 predictor
    write_sample(0, 0.0, 0.0, 0.0, 1'b1);
    write_sample(1, 0.0, 1.0, 1.0, 1'b1);
    write_sample(2, 1.0, 0.0, 1.0, 1'b1);
    write_sample(3, 1.0, 1.0, 0.0, 1'b1);

    launch(4, 3, 0.0, 0.5, 0);
    wait_done(400);
    check_result("xor_limit");
    chk_real("xor_limit.sse_is_one", bus.epoch_error, 1.0);
    chk_int("xor_limit.busy51", 32'(busy_cycles), 32'd51);
    chk_int("xor_limit.pulses12", 32'(pulses), 32'd12);

    launch(4, 3, 1.5, 0.5, 0);
    wait_done(400);
    check_result("xor_conv");
    chk_int("xor_conv.epoch1", 32'(bus.epoch_count), 32'd1);
    chk_int("xor_conv.converged", 32'(bus.converged), 32'd1);

    // Learning-rate halving every 2 epochs: 0.8 0.8 0.4 0.4 0.2
    launch(4, 5, 0.0, 0.8, 2);
    wait_done(600);
    check_result("lr_decay");
    chk_real("lr_decay.final_lr", mlp_lr, 0.2);

    // Abort during the second PRESENT, then relaunch from sample 0
    launch(4, 3, 0.0, 0.5, 0);
    wait_train(0, 50);
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk_int("stop.busy", 32'(bus.busy), 32'd0);
    chk_int("stop.done", 32'(bus.done), 32'd0);
    chk_int("stop.training", 32'(mlp_training), 32'd0);
    chk_int("stop.epoch_count_held", 32'(bus.epoch_count), 32'd0);
    launch(4, 2, 0.0, 0.5, 0);
    wait_done(400);
    check_result("after_stop");

    // Empty run
    launch(0, 3, 0.0, 0.5, 0);
    wait_done(5);
    check_result("zero_samples");
    chk_int("zero_samples.done", 32'(bus.done), 32'd1);

    // Write while busy must be dropped
    launch(4, 2, 0.0, 0.5, 0);
    repeat (5) @(negedge clk);
    write_sample(1, 7.0, 7.0, 7.0, 1'b0);
    wait_done(400);
    check_result("busy_write");

    // Randomized runs with a linear stub
    stub_a = rnd_q(); stub_b = rnd_q(); stub_c = rnd_q();
    for (int k = 0; k < MAXS; k++) write_sample(k, rnd_q(), rnd_q(), rnd_q(), 1'b1);
    for (int r = 0; r < 6; r++) begin
      n   = (r == 0) ? 20 : int'($urandom_range(16, 1));
      ep  = int'($urandom_range(4, 1));
      dec = int'($urandom_range(3, 0));
      thr = ($urandom_range(1) == 1) ? model_sse((n > MAXS) ? MAXS : n) + 0.125
                                     : model_sse((n > MAXS) ? MAXS : n) / 2.0;
      launch(n, ep, thr, rnd_q() + 4.0, dec);
      wait_done(400);
      check_result($sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of TRAIN
    launch(3, 4, 0.0, 1.0, 0);
    wait_train(1, 100);
    rst = 1'b1;
    #1;
    chk_int("arst.busy", 32'(bus.busy), 32'd0);
    chk_int("arst.training", 32'(mlp_training), 32'd0);
    chk_int("arst.epoch_count", 32'(bus.epoch_count), 32'd0);
    chk_int("arst.sample_idx", 32'(bus.sample_idx), 32'd0);
    chk_real("arst.epoch_error", bus.epoch_error, 0.0);
    chk_real("arst.lr", mlp_lr, 0.0);
    chk_real("arst.in0", mlp_in[0], 0.0);
    @(negedge clk);
    rst = 1'b0;

    // Buffer survives reset
    launch(4, 1, 0.0, 0.5, 0);
    wait_done(100);
    check_result("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
